// File: rtl/veggie_sched_if.sv
// Issue/writeback/bank-side signal bundle for the veggie register-file scheduler.
// The master drives requests and writes; the slave, which is the scheduler, drives bank controls and the response.
interface veggie_sched_if #(
    parameter int BANK_COUNT = 4,
    parameter int VREG_COUNT = 256
);
    localparam int REG_W = $clog2(VREG_COUNT);
    localparam int BW    = $clog2(BANK_COUNT);
    localparam int ROW_W = REG_W - BW;

    logic                        req_valid;
    logic                        req_ready;
    logic [REG_W-1:0]            req_vs1;
    logic [REG_W-1:0]            req_vs2;
    logic                        req_rd1_en;
    logic                        req_rd2_en;
    logic                        wr_valid;
    logic [REG_W-1:0]            wr_vd;
    logic                        wr_ready;
    logic [BANK_COUNT-1:0]       bank_ren;
    logic [BANK_COUNT*ROW_W-1:0] bank_raddr;
    logic [BANK_COUNT-1:0]       bank_wen;
    logic [ROW_W-1:0]            bank_waddr;
    logic                        cap1;
    logic                        cap2;
    logic [BW-1:0]               cap1_bsel;
    logic [BW-1:0]               cap2_bsel;
    logic                        resp_valid;
    logic                        resp_ready;
    logic                        busy;

    modport master (
        output req_valid, req_vs1, req_vs2, req_rd1_en, req_rd2_en,
        output wr_valid, wr_vd, resp_ready,
        input  req_ready, wr_ready, bank_ren, bank_raddr, bank_wen, bank_waddr,
        input  cap1, cap2, cap1_bsel, cap2_bsel, resp_valid, busy
    );

    modport slave (
        input  req_valid, req_vs1, req_vs2, req_rd1_en, req_rd2_en,
        input  wr_valid, wr_vd, resp_ready,
        output req_ready, wr_ready, bank_ren, bank_raddr, bank_wen, bank_waddr,
        output cap1, cap2, cap1_bsel, cap2_bsel, resp_valid, busy
    );
endinterface

// File: rtl/veggie_sched.sv
// Bank-access scheduler for the banked vector register file: it serialises read/read and read/write bank conflicts.
// The scheduler takes one two-operand request at a time and accepts writes every cycle unless a read is starving.
module veggie_sched #(
    parameter int BANK_COUNT = 4,
    parameter int VREG_COUNT = 256,
    parameter int STARVE_MAX = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    veggie_sched_if.slave bus
);
    localparam int REG_W = $clog2(VREG_COUNT);
    localparam int BW    = $clog2(BANK_COUNT);
    localparam int ROW_W = REG_W - BW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t           state_q, state_d;
    logic [REG_W-1:0] vs1_q, vs1_d, vs2_q, vs2_d;
    logic             pend1_q, pend1_d, pend2_q, pend2_d;
    logic [1:0]       blk_cnt_q, blk_cnt_d;
    logic             cap1_q, cap2_q;
    logic [BW-1:0]    cap1_bsel_q, cap2_bsel_q;

    logic [BW-1:0]    bank1, bank2, wbank;
    logic [ROW_W-1:0] row1, row2, wrow;
    logic             wr_ready_w, wr_fire, blk1, blk2, rr_conflict;
    logic             iss1, iss2, wr_blocked;

    assign bank1 = vs1_q[BW-1:0];
    assign row1  = vs1_q[REG_W-1:BW];
    assign bank2 = vs2_q[BW-1:0];
    assign row2  = vs2_q[REG_W-1:BW];
    assign wbank = bus.wr_vd[BW-1:0];
    assign wrow  = bus.wr_vd[REG_W-1:BW];

    assign wr_ready_w  = !(state_q == ISSUE && blk_cnt_q == 2'(STARVE_MAX));
    assign wr_fire     = bus.wr_valid && wr_ready_w;
    assign blk1        = wr_fire && (bank1 == wbank);
    assign blk2        = wr_fire && (bank2 == wbank);
    // Same bank and different rows: op2 yields to op1. If the register is the same, both share one read.
    assign rr_conflict = pend1_q && (bank1 == bank2) && (row1 != row2);
    assign iss1        = (state_q == ISSUE) && pend1_q && !blk1;
    assign iss2        = (state_q == ISSUE) && pend2_q && !blk2 && !rr_conflict;
    assign wr_blocked  = (state_q == ISSUE) && ((pend1_q && blk1) || (pend2_q && blk2));

    always_comb begin
        bus.bank_ren   = '0;
        bus.bank_raddr = '0;
        if (iss2) begin
            bus.bank_ren[bank2] = 1'b1;
            bus.bank_raddr[int'(bank2)*ROW_W +: ROW_W] = row2;
        end
        if (iss1) begin
            bus.bank_ren[bank1] = 1'b1;
            bus.bank_raddr[int'(bank1)*ROW_W +: ROW_W] = row1;
        end
    end

    assign bus.bank_wen   = wr_fire ? (BANK_COUNT'(1) << wbank) : '0;
    assign bus.bank_waddr = wr_fire ? wrow : '0;
    assign bus.wr_ready   = wr_ready_w;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.cap1       = cap1_q;
    assign bus.cap2       = cap2_q;
    assign bus.cap1_bsel  = cap1_bsel_q;
    assign bus.cap2_bsel  = cap2_bsel_q;

    always_comb begin
        state_d   = state_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        pend1_d   = pend1_q;
        pend2_d   = pend2_q;
        blk_cnt_d = blk_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    vs1_d   = bus.req_vs1;
                    vs2_d   = bus.req_vs2;
                    pend1_d = bus.req_rd1_en;
                    pend2_d = bus.req_rd2_en;
                    state_d = (bus.req_rd1_en || bus.req_rd2_en) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                pend1_d = pend1_q && !iss1;
                pend2_d = pend2_q && !iss2;
                if (iss1 || iss2)
                    blk_cnt_d = '0;
                else if (wr_blocked && blk_cnt_q != 2'd3)
                    blk_cnt_d = blk_cnt_q + 2'd1;
                if (!pend1_d && !pend2_d) begin
                    state_d   = DRAIN;
                    blk_cnt_d = '0;
                end
            end
            DRAIN: state_d = RESP;
            RESP: begin
                if (bus.resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            vs1_q       <= '0;
            vs2_q       <= '0;
            pend1_q     <= 1'b0;
            pend2_q     <= 1'b0;
            blk_cnt_q   <= '0;
            cap1_q      <= 1'b0;
            cap2_q      <= 1'b0;
            cap1_bsel_q <= '0;
            cap2_bsel_q <= '0;
        end else begin
            state_q     <= state_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            pend1_q     <= pend1_d;
            pend2_q     <= pend2_d;
            blk_cnt_q   <= blk_cnt_d;
            cap1_q      <= iss1;
            cap2_q      <= iss2;
            cap1_bsel_q <= iss1 ? bank1 : '0;
            cap2_bsel_q <= iss2 ? bank2 : '0;
        end
    end
endmodule

// File: tb/tb_veggie_sched.sv
// Bench for veggie_sched: it runs directed latency scenarios and random traffic against a transaction-level reference model.
module tb_veggie_sched;
    localparam int NB    = 4;
    localparam int NV    = 256;
    localparam int SM    = 2;
    localparam int REG_W = $clog2(NV);
    localparam int BW    = $clog2(NB);
    localparam int ROW_W = REG_W - BW;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    veggie_sched_if #(.BANK_COUNT(NB), .VREG_COUNT(NV)) bus ();
    veggie_sched #(.BANK_COUNT(NB), .VREG_COUNT(NV), .STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus)
    );

    // Reference model: phase 0 idle, 1 issuing, 2 drain, 3 response.
    int m_phase, m_starve;
    int m_reg [2];
    bit m_pend [2];
    bit m_cap [2];
    int m_capb [2];

    int vecs = 0, errs = 0;
    logic [NB-1:0] obs_ren;
    bit obs_wrdy, obs_resp;
    bit rq_wrdy [0:31];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_starve = 0;
        for (int k = 0; k < 2; k++) begin
            m_reg[k] = 0; m_pend[k] = 0; m_cap[k] = 0; m_capb[k] = 0;
        end
    endtask

    task automatic reset_check(input string tag);
        bus.req_valid = 0; bus.wr_valid = 0; bus.resp_ready = 0;
        nRST = 0;
        #1;
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_wr_ready"}, bus.wr_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_caps"}, {bus.cap1, bus.cap2, bus.cap1_bsel, bus.cap2_bsel}, 0);
        chk({tag, "_bank"}, {bus.bank_ren, bus.bank_raddr, bus.bank_wen, bus.bank_waddr}, 0);
        model_reset();
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
    endtask

    // The task drives one cycle just after the edge, checks all outputs mid-cycle, and advances the model.
    task automatic step(input bit rv, input int vs1, input int vs2, input bit e1, input bit e2,
                        input bit wv, input int wvd, input bit rr);
        bit wrdy, wfire, blocked;
        bit go [2];
        int wb, bk;
        logic [NB-1:0] e_ren, e_wen;
        logic [NB*ROW_W-1:0] e_raddr;
        logic [ROW_W-1:0] e_waddr;
        bus.req_valid = rv; bus.req_vs1 = REG_W'(vs1); bus.req_vs2 = REG_W'(vs2);
        bus.req_rd1_en = e1; bus.req_rd2_en = e2;
        bus.wr_valid = wv; bus.wr_vd = REG_W'(wvd); bus.resp_ready = rr;
        @(negedge CLK);
        wrdy  = !(m_phase == 1 && m_starve == SM);
        wfire = wv && wrdy;
        wb    = wvd % NB;
        go[0] = 0; go[1] = 0; blocked = 0;
        if (m_phase == 1) begin
            for (int k = 0; k < 2; k++)
                if (m_pend[k]) begin
                    if (wfire && (m_reg[k] % NB) == wb) blocked = 1;
                    else go[k] = 1;
                end
            if (m_pend[0] && (m_reg[0] % NB) == (m_reg[1] % NB) && m_reg[0] != m_reg[1])
                go[1] = 0;
        end
        e_ren = '0; e_raddr = '0;
        for (int k = 0; k < 2; k++)
            if (go[k]) begin
                bk = m_reg[k] % NB;
                e_ren[bk] = 1'b1;
                e_raddr[bk*ROW_W +: ROW_W] = ROW_W'(m_reg[k] / NB);
            end
        e_wen   = wfire ? NB'(1 << wb) : '0;
        e_waddr = wfire ? ROW_W'(wvd / NB) : '0;

        chk("req_ready", bus.req_ready, m_phase == 0);
        chk("busy", bus.busy, m_phase != 0);
        chk("resp_valid", bus.resp_valid, m_phase == 3);
        chk("wr_ready", bus.wr_ready, wrdy);
        chk("cap1", bus.cap1, m_cap[0]);
        chk("cap2", bus.cap2, m_cap[1]);
        chk("cap1_bsel", bus.cap1_bsel, m_capb[0]);
        chk("cap2_bsel", bus.cap2_bsel, m_capb[1]);
        chk("bank_ren", bus.bank_ren, e_ren);
        chk("bank_raddr", bus.bank_raddr, e_raddr);
        chk("bank_wen", bus.bank_wen, e_wen);
        chk("bank_waddr", bus.bank_waddr, e_waddr);
        obs_ren = bus.bank_ren; obs_wrdy = bus.wr_ready; obs_resp = bus.resp_valid;

        for (int k = 0; k < 2; k++) begin
            m_cap[k]  = go[k];
            m_capb[k] = go[k] ? (m_reg[k] % NB) : 0;
        end
        case (m_phase)
            0: if (rv) begin
                m_reg[0] = vs1; m_reg[1] = vs2; m_pend[0] = e1; m_pend[1] = e2;
                m_phase = (e1 || e2) ? 1 : 3;
            end
            1: begin
                if (go[0] || go[1]) m_starve = 0;
                else if (blocked) m_starve++;
                for (int k = 0; k < 2; k++) if (go[k]) m_pend[k] = 0;
                if (!m_pend[0] && !m_pend[1]) begin m_phase = 2; m_starve = 0; end
            end
            2: m_phase = 3;
            default: if (rr) m_phase = 0;
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic run_req(input string tag, input int vs1, input int vs2, input bit e1, input bit e2,
                           input bit wv, input int wvd, input int exp_lat, input logic [NB-1:0] exp_ren1);
        int lat;
        lat = -1;
        step(1, vs1, vs2, e1, e2, wv, wvd, 1);
        rq_wrdy[0] = obs_wrdy;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            step(0, 0, 0, 0, 0, wv, wvd, 1);
            rq_wrdy[c] = obs_wrdy;
            if (c == 1) chk({tag, "_ren_t1"}, obs_ren, exp_ren1);
            if (obs_resp) lat = c;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int vs1, vs2, wvd;
        model_reset();
        bus.req_vs1 = 0; bus.req_vs2 = 0; bus.req_rd1_en = 0; bus.req_rd2_en = 0; bus.wr_vd = 0;
        reset_check("por");

        run_req("no_conflict", 5, 10, 1, 1, 0, 0, 3, 4'b0110);
        run_req("rr_conflict", 4, 8, 1, 1, 0, 0, 4, 4'b0001);
        run_req("same_reg", 7, 7, 1, 1, 0, 0, 3, 4'b1000);
        run_req("starve", 1, 0, 1, 0, 1, 9, 5, 4'b0000);
        chk("starve_wr_ready_t2", rq_wrdy[2], 1);
        chk("starve_wr_ready_t3", rq_wrdy[3], 0);
        run_req("write_other_bank", 1, 6, 1, 1, 1, 11, 3, 4'b0110);

        step(1, 2, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 5, 10, 1, 1, 0, 0, 0);
            chk("hold_resp_valid", obs_resp, 1);
            chk("hold_ren", obs_ren, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        step(1, 5, 10, 1, 1, 0, 0, 1);
        reset_check("mid_issue");
        run_req("after_reset", 5, 10, 1, 1, 0, 0, 3, 4'b0110);

        for (int n = 0; n < 600; n++) begin
            vs1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NV-1) : $urandom_range(0, 15);
            vs2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NV-1) : $urandom_range(0, 15);
            wvd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NV-1) : $urandom_range(0, 15);
            step($urandom_range(0, 1), vs1, vs2, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 9) < 6, wvd, $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
